psram_qpi_responder: RTL and testbench

PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

---
 rtl/psram_resp_pkg.sv | 25 ++
 rtl/psram_resp_mem.sv | 23 ++
 rtl/psram_qpi_responder.sv | 208 ++++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_resp_pkg.sv
// Shared opcodes, FSM state type and nibble helper for the PSRAM QPI responder.
package psram_resp_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
  localparam logic [7:0] OP_QUAD_WRITE = 8'h38;
  localparam logic [7:0] OP_ENTER_QPI  = 8'h35;
  localparam logic [7:0] OP_EXIT_QPI   = 8'hF5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  function automatic logic [3:0] nib_sel(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Single-port byte RAM, 2^ADDR_W x 8, synchronous write, 1-clk registered read.
module psram_resp_mem #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM QPI slave model: quad read (0xEB) / quad write (0x38) into an internal byte RAM.
// Optional macro PSRAM_RESP_SPI_INIT_EN: start in 1-bit SPI mode, 0x35 enters QPI, 0xF5 leaves it.
module psram_qpi_responder
  import psram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psram_nce,
  input  logic       psram_sclk,
  input  logic [3:0] psram_sin,
  output logic [3:0] psram_sout,
  output logic       psram_oe,
  output logic       cmd_err
);

  logic [1:0] nce_sync_q;
  logic [1:0] sclk_sync_q;
  logic [3:0] sin_m_q;
  logic [3:0] sin_s_q;
  logic       nce_prev_q;
  logic       sclk_prev_q;

  logic nce_s_c;
  logic sclk_s_c;
  logic nce_fall_c;
  logic sclk_rise_c;
  logic sclk_fall_c;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      nce_sync_q  <= '0;
      sclk_sync_q <= '0;
      sin_m_q     <= '0;
      sin_s_q     <= '0;
      nce_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      nce_sync_q  <= {nce_sync_q[0], psram_nce};
      sclk_sync_q <= {sclk_sync_q[0], psram_sclk};
      sin_m_q     <= psram_sin;
      sin_s_q     <= sin_m_q;
      nce_prev_q  <= nce_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign nce_s_c     = nce_sync_q[1];
  assign sclk_s_c    = sclk_sync_q[1];
  assign nce_fall_c  = nce_prev_q & ~nce_s_c;
  assign sclk_rise_c = sclk_s_c & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_s_c & sclk_prev_q;

  state_e            state_q;
  logic [7:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              half_q;
  logic [3:0]        hi_q;
  logic [3:0]        sout_q;
  logic              oe_q;
  logic              err_q;
  logic [7:0]        rdata_c;
  logic [7:0]        op_next_c;
  logic [CNT_W-1:0]  cmd_last_c;
  logic              mem_we_c;

`ifdef PSRAM_RESP_SPI_INIT_EN
  logic qpi_q;
  assign op_next_c  = qpi_q ? {op_q[3:0], sin_s_q} : {op_q[6:0], sin_s_q[0]};
  assign cmd_last_c = qpi_q ? CNT_W'(1) : CNT_W'(7);
`else
  assign op_next_c  = {op_q[3:0], sin_s_q};
  assign cmd_last_c = CNT_W'(1);
`endif

  assign mem_we_c = (state_q == ST_WDATA) && sclk_rise_c && half_q && !nce_s_c;

  psram_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we_c),
    .addr_i  (addr_q),
    .wdata_i ({hi_q, sin_s_q}),
    .rdata_o (rdata_c)
  );

  // Transaction FSM; nce high overrides everything and drops the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      hi_q    <= '0;
      sout_q  <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef PSRAM_RESP_SPI_INIT_EN
      qpi_q   <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      if (nce_s_c) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        sout_q  <= '0;
        half_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (nce_fall_c) begin
              state_q <= ST_CMD;
              cnt_q   <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise_c) begin
              op_q  <= op_next_c;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == cmd_last_c) begin
                cnt_q <= '0;
`ifdef PSRAM_RESP_SPI_INIT_EN
                if (qpi_q && (op_next_c == OP_QUAD_READ || op_next_c == OP_QUAD_WRITE)) begin
                  state_q <= ST_ADDR;
                end else if (!qpi_q && op_next_c == OP_ENTER_QPI) begin
                  qpi_q   <= 1'b1;
                  state_q <= ST_IGNORE;
                end else if (qpi_q && op_next_c == OP_EXIT_QPI) begin
                  qpi_q   <= 1'b0;
                  state_q <= ST_IGNORE;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_IGNORE;
                end
`else
                if (op_next_c == OP_QUAD_READ || op_next_c == OP_QUAD_WRITE) begin
                  state_q <= ST_ADDR;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= ST_IGNORE;
                end
`endif
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_c) begin
              // Shifting all 24 bits through an ADDR_W register keeps only the low bits
              addr_q <= {addr_q[ADDR_W-5:0], sin_s_q};
              cnt_q  <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(5)) begin
                cnt_q  <= '0;
                half_q <= 1'b0;
                if (op_q == OP_QUAD_READ) begin
                  state_q <= (WAIT_CYCLES == 0) ? ST_RDATA : ST_WAIT;
                end else begin
                  state_q <= ST_WDATA;
                end
              end
            end
          end
          ST_WAIT: begin
            if (sclk_rise_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                state_q <= ST_RDATA;
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall_c) begin
              oe_q   <= 1'b1;
              sout_q <= nib_sel(rdata_c, !half_q);
              half_q <= !half_q;
              if (half_q) begin
                addr_q <= addr_q + ADDR_W'(1);
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise_c) begin
              half_q <= !half_q;
              if (!half_q) begin
                hi_q <= sin_s_q;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
              end
            end
          end
          ST_IGNORE: begin
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign psram_sout = sout_q;
  assign psram_oe   = oe_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Randomized scoreboard bench for psram_qpi_responder against a byte-array memory model.
module tb_psram_qpi_responder;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned WAIT_CYCLES = 6;
  localparam int          HALF        = 8;
  localparam logic [7:0]  OP_R        = 8'hEB;
  localparam logic [7:0]  OP_W        = 8'h38;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psram_nce = 1'b1;
  logic       psram_sclk = 1'b0;
  logic [3:0] psram_sin = '0;
  logic [3:0] psram_sout;
  logic       psram_oe;
  logic       cmd_err;

  int compared   = 0;
  int mismatched = 0;
  int err_cnt    = 0;

  logic [7:0] mem_m [0:65535];
  logic [3:0] exp_q [$];
  logic [7:0] wq [$];

  always #5 clk = ~clk;

  psram_qpi_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psram_nce  (psram_nce),
    .psram_sclk (psram_sclk),
    .psram_sin  (psram_sin),
    .psram_sout (psram_sout),
    .psram_oe   (psram_oe),
    .cmd_err    (cmd_err)
  );

  function automatic void chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  always @(posedge clk) if (cmd_err) err_cnt++;

  // Monitor: every host sample edge with the bus driven must match the next expected nibble
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge psram_sclk);
      if (psram_oe) begin
        if (exp_q.size() == 0) begin
          chk("oe_unexpected", psram_oe, 0);
        end else begin
          e = exp_q.pop_front();
          chk("read_nibble", psram_sout, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] nib);
    psram_sin = nib;
    tick(HALF);
    psram_sclk = 1'b1;
    tick(HALF);
    psram_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc(b[7:4]);
    cyc(b[3:0]);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    tick(HALF);
    psram_nce = 1'b0;
    send_byte(op);
    for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
  endtask

  task automatic tx_end;
    tick(HALF);
    psram_nce = 1'b1;
    tick(6);
    chk("oe_after_nce", psram_oe, 0);
  endtask

  function automatic logic [15:0] wrap(input logic [23:0] a, input int i);
    return 16'(a[15:0] + 16'(i));
  endfunction

  // Writes the bytes queued in wq starting at a, updating the model
  task automatic write_tx(input logic [23:0] a);
    send_hdr(OP_W, a);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i]);
      mem_m[wrap(a, i)] = wq[i];
    end
    wq.delete();
    tx_end();
  endtask

  task automatic write_rand(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
    write_tx(a);
  endtask

  task automatic read_tx(input logic [23:0] a, input int n);
    logic [7:0] b;
    send_hdr(OP_R, a);
    repeat (WAIT_CYCLES) cyc(4'($urandom_range(0, 15)));
    for (int i = 0; i < n; i++) begin
      b = mem_m[wrap(a, i)];
      exp_q.push_back(b[7:4]);
      cyc(4'($urandom_range(0, 15)));
      exp_q.push_back(b[3:0]);
      cyc(4'($urandom_range(0, 15)));
    end
    tx_end();
    chk("read_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic bad_tx(input logic [7:0] op);
    int e0;
    e0 = err_cnt;
    send_hdr(op, 24'($urandom));
    repeat (4) cyc(4'($urandom_range(0, 15)));
    tx_end();
    chk("cmd_err_pulses", err_cnt - e0, 1);
  endtask

  initial begin
    logic [7:0] d1;
    logic [7:0] b;
    logic [7:0] op35;

    tick(4);
    chk("rst_oe", psram_oe, 0);
    chk("rst_sout", psram_sout, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    tick(4);

`ifdef PSRAM_RESP_SPI_INIT_EN
    // In SPI mode the QPI header bit0 stream decodes as 0x42: rejected, no data driven
    begin
      int e0;
      e0 = err_cnt;
      send_hdr(OP_R, 24'h000010);
      repeat (WAIT_CYCLES + 4) cyc(4'($urandom_range(0, 15)));
      tx_end();
      chk("spi_qpi_read_ignored", err_cnt - e0, 1);
    end
    op35 = 8'h35;
    tick(HALF);
    psram_nce = 1'b0;
    for (int i = 7; i >= 0; i--) cyc({3'b000, op35[i]});
    tx_end();
`else
    op35 = 8'h35;
    bad_tx(op35);
    bad_tx(8'hF5);
`endif

    // Known contents for every address the bench reads
    write_rand(24'h000000, 64);
    write_rand(24'h00FFC0, 64);

    wq.push_back(8'hA5);
    wq.push_back(8'h3C);
    write_tx(24'h000010);
    read_tx(24'h000010, 2);

    wq.push_back(8'hFF);
    wq.push_back(8'h11);
    write_tx(24'h00FFFF);
    read_tx(24'h00FFFF, 2);
    read_tx(24'h000000, 1);

    bad_tx(8'h9F);
    read_tx(24'h000010, 2);

    // Partial second byte is dropped when nce rises
    d1 = 8'($urandom);
    send_hdr(OP_W, 24'h000020);
    send_byte(d1);
    cyc(4'($urandom_range(0, 15)));
    tx_end();
    mem_m[16'h0020] = d1;
    read_tx(24'h000020, 2);

    // Reset during read data
    send_hdr(OP_R, 24'h000030);
    repeat (WAIT_CYCLES) cyc(4'($urandom_range(0, 15)));
    b = mem_m[16'h0030];
    exp_q.push_back(b[7:4]);
    cyc(4'h0);
    exp_q.push_back(b[3:0]);
    cyc(4'h0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_oe", psram_oe, 0);
    chk("midrst_sout", psram_sout, 0);
    rst = 1'b0;
    repeat (3) cyc(4'($urandom_range(0, 15)));
    tx_end();
    read_tx(24'h000030, 3);

    for (int t = 0; t < 40; t++) begin
      int unsigned kind;
      int          n;
      logic [15:0] base;
      logic [23:0] a;
      logic [7:0]  op;
      kind = $urandom_range(0, 9);
      n    = $urandom_range(1, 6);
      base = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 48))
                                         : 16'($urandom_range(16'hFFC0, 16'hFFFF));
      a    = {8'($urandom), base};
      if (kind < 4) begin
        write_rand(a, n);
      end else if (kind < 9) begin
        read_tx(a, n);
      end else begin
        do op = 8'($urandom);
        while (op == OP_R || op == OP_W || op == 8'h35 || op == 8'hF5);
        bad_tx(op);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
